tri_xor3_fold_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH-bit, three-input XOR fold engine among NREQ requesters.
- Each requester streams a multi-beat message with a valid/ready handshake. The engine folds every accepted beat with a per-requester key into an accumulator.
- Returns one result per message (accumulator, requester id, beat count) on a valid/ready result port.
- Used for parity/checksum generation ahead of array writes.

---
 rtl/tri_xor3_fold_arb.sv | 161 ++++++++++++++++
 tb/tb_tri_xor3_fold_arb.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_xor3_fold_arb.sv
// Round-robin arbiter sharing one three-input XOR fold engine among NREQ streaming requesters.
// Latency: 1 arbitration cycle, then 1 beat/cycle; result valid the cycle after the last beat.
// Backpressure: req_ready only for the granted requester in BUSY; RESULT holds until res_ready.
module tri_xor3_fold_arb #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  cfg_we,
    input  logic [IDW-1:0]        cfg_idx,
    input  logic [WIDTH-1:0]      cfg_key,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id,
    output logic [CNTW-1:0]       res_beats
);

    typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_t;

    localparam int             NREQ_M1 = NREQ - 1;
    localparam logic [IDW:0]   NREQ_L  = NREQ[IDW:0];
    localparam logic [IDW-1:0] LAST_ID = NREQ_M1[IDW-1:0];

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr, grant;
    logic [WIDTH-1:0] acc;
    logic [CNTW-1:0]  cnt, cnt_inc;
    logic [WIDTH-1:0] key [NREQ];

    logic [2*NREQ-1:0] dbl_vld;
    logic [NREQ-1:0]   rot_vld;
    logic [IDW-1:0]    arb_off, arb_idx;
    logic [IDW:0]      arb_sum;
    logic              arb_hit;

    logic [WIDTH-1:0] beat_data, beat_key, fold;
    logic             beat_vld, beat_last, beat_fire;

    // Rotate the valid vector so bit 0 is rr_ptr; lowest set bit is the winner.
    always_comb begin
        dbl_vld = {req_valid, req_valid};
        rot_vld = NREQ'(dbl_vld >> rr_ptr);
        arb_hit = 1'b0;
        arb_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_vld[k]) begin
                arb_hit = 1'b1;
                arb_off = IDW'(k);
            end
        end
        arb_sum = {1'b0, rr_ptr} + {1'b0, arb_off};
        if (arb_sum >= NREQ_L) begin
            arb_sum = arb_sum - NREQ_L;
        end
        arb_idx = arb_sum[IDW-1:0];
    end

    always_comb begin
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        beat_data = '0;
        beat_key  = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                beat_vld     = req_valid[i];
                beat_last    = req_last[i];
                beat_data    = req_data[i*WIDTH +: WIDTH];
                beat_key     = key[i];
                req_ready[i] = (state == BUSY);
            end
        end
    end

    assign beat_fire = (state == BUSY) && beat_vld;
    assign cnt_inc   = (&cnt) ? cnt : cnt + CNTW'(1);
    assign res_valid = (state == RESULT);

    for (genvar b = 0; b < WIDTH; b++) begin : g_fold
        xor3_cell u_xor3 (
            .a (acc[b]),
            .b (beat_data[b]),
            .c (beat_key[b]),
            .y (fold[b])
        );
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (arb_hit) state_nxt = BUSY;
            BUSY:    if (beat_fire && beat_last) state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            grant     <= '0;
            acc       <= '0;
            cnt       <= '0;
            res_data  <= '0;
            res_id    <= '0;
            res_beats <= '0;
            for (int i = 0; i < NREQ; i++) begin
                key[i] <= '0;
            end
        end else begin
            if (state == IDLE && arb_hit) begin
                grant <= arb_idx;
                acc   <= '0;
                cnt   <= '0;
            end
            if (beat_fire) begin
                acc <= fold;
                cnt <= cnt_inc;
                if (beat_last) begin
                    res_data  <= fold;
                    res_id    <= grant;
                    res_beats <= cnt_inc;
                    rr_ptr    <= (grant == LAST_ID) ? '0 : grant + 1'b1;
                end
            end
            // Indices at or above NREQ match no entry and are dropped.
            for (int i = 0; i < NREQ; i++) begin
                if (cfg_we && cfg_idx == IDW'(i)) begin
                    key[i] <= cfg_key;
                end
            end
        end
    end

endmodule

// Single-bit three-input XOR cell used as the fold engine's bit slice.
module xor3_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = a ^ b ^ c;
endmodule

// File: tb/tb_tri_xor3_fold_arb.sv
// Scoreboard bench for tri_xor3_fold_arb: tasks drive messages, a monitor pops expected results.
module tb_tri_xor3_fold_arb;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 3;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*W-1:0]  req_data;
    logic            cfg_we;
    logic [IW-1:0]   cfg_idx;
    logic [W-1:0]    cfg_key;
    logic            res_valid, res_ready;
    logic [W-1:0]    res_data;
    logic [IW-1:0]   res_id;
    logic [CW-1:0]   res_beats;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
        logic [CW-1:0] beats;
    } res_t;

    res_t       sb_q[$];
    res_t       mon_exp;
    logic [W-1:0] key_m [N];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tri_xor3_fold_arb #(.WIDTH(W), .NREQ(N), .IDW(IW), .CNTW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_key   (cfg_key),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_beats (res_beats)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got id=%0d data=%h beats=%0d, required no result",
                         res_id, res_data, res_beats);
            end else begin
                mon_exp = sb_q.pop_front();
                if (res_id !== mon_exp.id || res_data !== mon_exp.data || res_beats !== mon_exp.beats) begin
                    n_fail++;
                    $display("FAIL result: got id=%0d data=%h beats=%0d, required id=%0d data=%h beats=%0d",
                             res_id, res_data, res_beats, mon_exp.id, mon_exp.data, mon_exp.beats);
                end
            end
        end
    end

    task automatic expect_res(input int id, input logic [W-1:0] d, input int beats);
        res_t e;
        e.id    = IW'(id);
        e.data  = d;
        e.beats = CW'(beats);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        req_valid = '0; req_last = '0; req_data = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_key = '0; res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < N; i++) key_m[i] = '0;
    endtask

    task automatic cfg_write(input logic [IW-1:0] idx, input logic [W-1:0] k);
        cfg_we = 1'b1; cfg_idx = idx; cfg_key = k;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        if (int'(idx) < N) key_m[int'(idx)] = k;
    endtask

    task automatic beat(input int id, input logic [W-1:0] d, input logic last);
        int t;
        t = 0;
        req_valid[id] = 1'b1;
        req_last[id]  = last;
        req_data[id*W +: W] = d;
        @(negedge clk);
        while (req_ready[id] !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            n_checks++; n_fail++;
            $display("FAIL beat_timeout: req %0d req_ready=%b, required 1", id, req_ready[id]);
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: %0d results outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        req_last = '1; cfg_we = 1'b0; cfg_idx = '0; cfg_key = '0; res_ready = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(32'hA0 + i);
        req_valid = '1;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== '0 || res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 || res_beats !== '0) begin
                n_fail++;
                $display("FAIL reset_state: got ready=%b vld=%b data=%h id=%0d beats=%0d, required all 0",
                         req_ready, res_valid, res_data, res_id, res_beats);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < N; i++) key_m[i] = '0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_arb_cycle: got req_ready=%b, required 0000", req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got req_ready=%b, required 0001", req_ready);
        end
        expect_res(0, 32'h0000_00A0, 1);
        res_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = '0; req_last = '0;
        drain("reset");
    endtask

    task automatic test_single_3beat();
        do_reset();
        cfg_write(3'd1, 32'h0000_00FF);
        beat(1, 32'h1111_1111, 1'b0);
        beat(1, 32'h2222_2222, 1'b0);
        beat(1, 32'h4444_4444, 1'b1);
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 32'h7777_7788 || res_id !== 3'd1 || res_beats !== 8'd3) begin
                n_fail++;
                $display("FAIL single_hold: got vld=%b data=%h id=%0d beats=%0d, required 1 77777788 1 3",
                         res_valid, res_data, res_id, res_beats);
            end
        end
        expect_res(1, 32'h7777_7788, 3);
        res_ready = 1'b1;
        drain("single");
    endtask

    task automatic test_round_robin();
        int prev, t;
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hC0DE_0000 | W'(i);
        for (int m = 0; m < 5; m++) expect_res(order[m], 32'hC0DE_0000 | W'(order[m]), 1);
        req_valid = '1; req_last = '1;
        prev = 0;
        for (int m = 0; m < 5; m++) begin
            t = 0;
            @(negedge clk);
            while (res_valid !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            n_checks++;
            if (t >= 20) begin
                n_fail++;
                $display("FAIL rr_timeout: message %0d res_valid=%b, required 1", m, res_valid);
            end else if (m > 0 && cyc - prev != 3) begin
                n_fail++;
                $display("FAIL rr_period: message %0d took %0d cycles, required 3", m, cyc - prev);
            end
            prev = cyc;
            if (m == 4) begin
                req_valid = '0; req_last = '0;
            end
        end
        drain("rr");
    endtask

    task automatic test_bubble();
        do_reset();
        res_ready = 1'b1;
        beat(2, 32'h2222_0001, 1'b0);
        req_data[3*W +: W] = 32'h3333_0003; req_last[3] = 1'b1; req_valid[3] = 1'b1;
        req_data[0*W +: W] = 32'h0000_0AAA; req_last[0] = 1'b1; req_valid[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 4'b0100) begin
                n_fail++;
                $display("FAIL bubble_hold: got req_ready=%b, required 0100", req_ready);
            end
        end
        expect_res(2, 32'h2222_0001 ^ 32'h2222_0010, 2);
        expect_res(3, 32'h3333_0003, 1);
        expect_res(0, 32'h0000_0AAA, 1);
        @(posedge clk);
        #1;
        beat(2, 32'h2222_0010, 1'b1);
        beat(3, 32'h3333_0003, 1'b1);
        beat(0, 32'h0000_0AAA, 1'b1);
        drain("bubble");
    endtask

    task automatic test_key_race();
        logic [W-1:0] k1, k2, d1, d2, d3;
        k1 = 32'h0F0F_0F0F; k2 = 32'hF00F_F00F;
        d1 = 32'h1357_9BDF; d2 = 32'h2468_ACE0; d3 = 32'h0BAD_CAFE;
        do_reset();
        res_ready = 1'b1;
        cfg_write(3'd5, 32'hDEAD_BEEF);
        expect_res(1, 32'h1234_5678, 1);
        beat(1, 32'h1234_5678, 1'b1);
        drain("bad_idx");
        cfg_write(3'd0, k1);
        beat(0, d1, 1'b0);
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_key = k2;
        beat(0, d2, 1'b0);
        cfg_we = 1'b0;
        expect_res(0, d1 ^ k1 ^ d2 ^ k1 ^ d3 ^ k2, 3);
        beat(0, d3, 1'b1);
        drain("key_race");
    endtask

    task automatic test_saturation();
        logic [W-1:0] acc_m, d;
        do_reset();
        res_ready = 1'b1;
        cfg_write(3'd3, 32'h5A5A_5A5A);
        acc_m = '0;
        for (int i = 0; i < 300; i++) begin
            d = W'(i) * 32'h9E37_79B9;
            acc_m = acc_m ^ d ^ key_m[3];
            if (i == 299) expect_res(3, acc_m, 255);
            beat(3, d, i == 299);
        end
        drain("saturation");
    endtask

    task automatic test_reset_abort();
        do_reset();
        res_ready = 1'b1;
        cfg_write(3'd0, 32'hFFFF_0000);
        expect_res(1, 32'h0000_0011, 1);
        beat(1, 32'h0000_0011, 1'b1);
        drain("pre_abort");
        beat(2, 32'h0000_0022, 1'b0);
        beat(2, 32'h0000_0023, 1'b0);
        req_valid[2] = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) key_m[i] = '0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL abort_idle: got vld=%b req_ready=%b, required 0 0000", res_valid, req_ready);
            end
        end
        req_data[0*W +: W] = 32'h0000_00A0; req_last[0] = 1'b1; req_valid[0] = 1'b1;
        req_data[3*W +: W] = 32'h0000_00D3; req_last[3] = 1'b1; req_valid[3] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_rr_ptr: got req_ready=%b, required 0001", req_ready);
        end
        expect_res(0, 32'h0000_00A0, 1);
        expect_res(3, 32'h0000_00D3, 1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0; req_last[0] = 1'b0;
        beat(3, 32'h0000_00D3, 1'b1);
        drain("abort");
    endtask

    initial begin
        test_reset();
        test_single_3beat();
        test_round_robin();
        test_bubble();
        test_key_race();
        test_saturation();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
